// File: rtl/lbm_seq_pkg.sv
// lbm_seq_pkg: shared definitions for the LBM step sequencer.
// Holds the FSM state encoding (the codes are visible to the HPS in status[6:4]),
// the status word bit map and the field positions inside the PIO command word.
package lbm_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_STEP       = 3'd1,
        S_WAIT_STEP  = 3'd2,
        S_PRINT      = 3'd3,
        S_WAIT_PRINT = 3'd4,
        S_DONE       = 3'd5
    } seq_state_t;

    // Status word bit map
    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_ABORTED   = 2;
    localparam int STAT_TIMEOUT   = 3;
    localparam int STAT_STATE_LSB = 4;
    localparam int STAT_STATE_MSB = 6;
    localparam int STAT_PRINTING  = 7;

    // Command word fields
    localparam int CMD_START   = 0;
    localparam int CMD_ABORT   = 1;
    localparam int CMD_IVL_LSB = 2;
    localparam int CMD_IVL_MSB = 7;
    localparam int IVL_W       = CMD_IVL_MSB - CMD_IVL_LSB + 1;

endpackage

// File: rtl/lbm_edge_det.sv
// lbm_edge_det: rising-edge detector for the start bit of the command word.
// The delayed copy is the registered command bit; the edge output is
// combinational and only feeds the sequencer's next-state logic.
module lbm_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_q;

    // Delay the sampled signal by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/lbm_step_sequencer.sv
// lbm_step_sequencer: control-plane sequencer between the HPS start PIO and
// the LBM solver core. Runs a latched number of solver iterations, inserts a
// readout phase every ivl iterations and once at the end of the run, and
// reports progress on an 8-bit status word.
// Optional feature: define LBM_SEQ_WATCHDOG_EN to bound the time spent in
// each wait state; on expiry status[3] is set and the block goes to DONE.
// Without the macro no watchdog counter exists and status[3] stays 0.
module lbm_step_sequencer
    import lbm_seq_pkg::*;
#(
    parameter int ITER_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        cmd,
    input  logic [ITER_W-1:0] num_iter,
    output logic              solver_start,
    input  logic              solver_done,
    output logic              print_start,
    input  logic              print_done,
    output logic              busy,
    output logic [ITER_W-1:0] iter_count,
    output logic [7:0]        status
);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [ITER_W-1:0] r_n_lat;
    logic [ITER_W-1:0] r_iter_count;
    logic [ITER_W-1:0] w_iter_plus1;
    logic [IVL_W-1:0]  r_ivl_lat;
    logic [IVL_W-1:0]  r_print_ctr;
    logic [IVL_W-1:0]  w_ivl_cmd;
    logic              r_done_flag;
    logic              r_abort_flag;
    logic              r_timeout_flag;
    logic              w_start_edge;
    logic              w_run_start;
    logic              w_active;
    logic              w_in_wait;
    logic              w_wd_expire;
    logic              w_iter_inc;
    logic              w_ctr_reload;
    logic              w_abort_hit;
    logic              w_timeout_hit;

    // The watchdog counter must be able to hold TIMEOUT_CYCLES - 1.
    if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_timeout_cfg
        $error("lbm_step_sequencer: TO_W is too narrow for TIMEOUT_CYCLES");
    end

    lbm_edge_det u_start_edge (
        .clk    (clk),
        .reset  (reset),
        .i_sig  (cmd[CMD_START]),
        .o_rise (w_start_edge)
    );

    assign w_ivl_cmd    = cmd[CMD_IVL_MSB:CMD_IVL_LSB];
    assign w_run_start  = (r_state == S_IDLE) && w_start_edge;
    assign w_active     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_in_wait    = (r_state == S_WAIT_STEP) || (r_state == S_WAIT_PRINT);
    assign w_iter_plus1 = r_iter_count + ITER_W'(1);

`ifdef LBM_SEQ_WATCHDOG_EN
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_wd_ctr;

    // Count cycles spent in a wait state; every wait state is entered from a
    // non-wait state, so clearing outside them is the same as clearing on entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_ctr <= '0;
        end else if (w_in_wait) begin
            r_wd_ctr <= r_wd_ctr + TO_W'(1);
        end else begin
            r_wd_ctr <= '0;
        end
    end

    assign w_wd_expire = w_in_wait && (r_wd_ctr == WD_LAST);
`else
    assign w_wd_expire = 1'b0;
`endif

    // Next-state and datapath-control decode
    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        w_next_state  = r_state;
        w_iter_inc    = 1'b0;
        w_ctr_reload  = 1'b0;
        w_abort_hit   = 1'b0;
        w_timeout_hit = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_next_state = (num_iter == '0) ? S_PRINT : S_STEP;
                end
            end
            S_STEP: begin
                w_next_state = S_WAIT_STEP;
            end
            S_WAIT_STEP: begin
                if (solver_done) begin
                    w_iter_inc = 1'b1;
                    if (w_iter_plus1 == r_n_lat) begin
                        w_next_state = S_PRINT;
                    end else if ((r_ivl_lat != '0) && (r_print_ctr == IVL_W'(1))) begin
                        w_ctr_reload = 1'b1;
                        w_next_state = S_PRINT;
                    end else begin
                        w_next_state = S_STEP;
                    end
                end else if (w_wd_expire) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = S_DONE;
                end
            end
            S_PRINT: begin
                w_next_state = S_WAIT_PRINT;
            end
            S_WAIT_PRINT: begin
                if (print_done) begin
                    w_next_state = (r_iter_count == r_n_lat) ? S_DONE : S_STEP;
                end else if (w_wd_expire) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = S_DONE;
                end
            end
            S_DONE: begin
                if (!cmd[CMD_START]) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a done pulse in the same cycle
        if (w_active && cmd[CMD_ABORT]) begin
            w_next_state  = S_IDLE;
            w_abort_hit   = 1'b1;
            w_iter_inc    = 1'b0;
            w_ctr_reload  = 1'b0;
            w_timeout_hit = 1'b0;
        end
    end

    // State register
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Run parameters, iteration/print counters and sticky status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n_lat        <= '0;
            r_ivl_lat      <= '0;
            r_print_ctr    <= '0;
            r_iter_count   <= '0;
            r_done_flag    <= 1'b0;
            r_abort_flag   <= 1'b0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (w_run_start) begin
                r_n_lat        <= num_iter;
                r_ivl_lat      <= w_ivl_cmd;
                r_print_ctr    <= w_ivl_cmd;
                r_iter_count   <= '0;
                r_done_flag    <= 1'b0;
                r_abort_flag   <= 1'b0;
                r_timeout_flag <= 1'b0;
            end
            if (w_iter_inc) begin
                r_iter_count <= w_iter_plus1;
                r_print_ctr  <= w_ctr_reload ? r_ivl_lat : (r_print_ctr - IVL_W'(1));
            end
            if (w_abort_hit) begin
                r_abort_flag <= 1'b1;
            end
            if (w_timeout_hit) begin
                r_timeout_flag <= 1'b1;
            end
            if ((w_next_state == S_DONE) && (r_state != S_DONE)) begin
                r_done_flag <= 1'b1;
            end
        end
    end

    assign solver_start = (r_state == S_STEP);
    assign print_start  = (r_state == S_PRINT);
    assign busy         = w_active;
    assign iter_count   = r_iter_count;

    assign status[STAT_BUSY]                     = w_active;
    assign status[STAT_DONE]                     = r_done_flag;
    assign status[STAT_ABORTED]                  = r_abort_flag;
    assign status[STAT_TIMEOUT]                  = r_timeout_flag;
    assign status[STAT_STATE_MSB:STAT_STATE_LSB] = r_state;
    assign status[STAT_PRINTING]                 = (r_state == S_PRINT) || (r_state == S_WAIT_PRINT);

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// tb_lbm_step_sequencer: self-checking bench for lbm_step_sequencer.
// A run-level reference model turns (num_iter, interval) into the expected
// ordered list of solver/print launches; the bench plays solver and readout
// engine with random latencies and stray pulses, and compares. Hand-written
// sequences cover abort, held start, mid-run reset and (with
// LBM_SEQ_WATCHDOG_EN) the watchdog.
module tb_lbm_step_sequencer;

`ifdef LBM_SEQ_WATCHDOG_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 1000000;
`endif
    localparam int RUN_BUDGET = 3000;
    localparam int EV_STEP    = 1;
    localparam int EV_PRINT   = 2;

    logic        clk;
    logic        reset;
    logic [7:0]  cmd;
    logic [15:0] num_iter;
    logic        solver_start;
    logic        solver_done;
    logic        print_start;
    logic        print_done;
    logic        busy;
    logic [15:0] iter_count;
    logic [7:0]  status;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int got_q[$];

    typedef struct {
        int n;
        int ivl;
        int exp_starts;
        int exp_prints;
    } vec_t;

    vec_t vecs[7];

    lbm_step_sequencer #(
        .ITER_W         (16),
        .TIMEOUT_CYCLES (TB_TO),
        .TO_W           (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cmd),
        .num_iter     (num_iter),
        .solver_start (solver_start),
        .solver_done  (solver_done),
        .print_start  (print_start),
        .print_done   (print_done),
        .busy         (busy),
        .iter_count   (iter_count),
        .status       (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired before the expected event", name);
    endtask

    // Reference model: a run of n iterations launches n solver steps; a
    // readout follows step k when k is the last step or a multiple of the
    // interval. An empty run is a single readout.
    function automatic void build_model(input int n, input int ivl);
        exp_q.delete();
        if (n == 0) exp_q.push_back(EV_PRINT);
        for (int k = 1; k <= n; k++) begin
            exp_q.push_back(EV_STEP);
            if (k == n || (ivl != 0 && (k % ivl) == 0)) exp_q.push_back(EV_PRINT);
        end
    endfunction

    // Execute one complete run, acting as solver and readout engine
    task automatic run_check(input int n, input int ivl, input int max_lat, input string tag,
                             output int n_starts, output int n_prints);
        int sd_pend, pd_pend;
        bit sd_new, pd_new, after_sd, after_pd, done_seen, first_cyc;
        build_model(n, ivl);
        got_q.delete();
        sd_pend = 0; pd_pend = 0; after_sd = 0; after_pd = 0; done_seen = 0; first_cyc = 1;
        n_starts = 0; n_prints = 0;
        solver_done = 1'b0; print_done = 1'b0;
        cmd = 8'h00;
        num_iter = 16'(n);
        @(negedge clk);
        @(negedge clk);
        cmd = {6'(ivl), 2'b01};
        for (int cyc = 0; cyc < RUN_BUDGET && !done_seen; cyc++) begin
            @(negedge clk);
            solver_done = 1'b0; print_done = 1'b0; sd_new = 0; pd_new = 0;
            if (first_cyc) begin
                check($sformatf("%s_start_latency", tag), {30'd0, solver_start, print_start},
                      (n == 0) ? 32'd1 : 32'd2);
                first_cyc = 0;
            end
            if (after_sd) begin
                check($sformatf("%s_solver_done_latency", tag), {31'd0, solver_start | print_start}, 32'd1);
                after_sd = 0;
            end
            if (after_pd) begin
                check($sformatf("%s_print_done_latency", tag),
                      {31'd0, solver_start | (status[6:4] == 3'd5)}, 32'd1);
                after_pd = 0;
            end
            if (solver_start) begin
                got_q.push_back(EV_STEP);
                n_starts++;
                sd_pend = 1 + int'($urandom_range(0, max_lat));
                sd_new = 1;
            end
            if (print_start) begin
                got_q.push_back(EV_PRINT);
                n_prints++;
                check($sformatf("%s_printing_flag", tag), {30'd0, status[7], status[0]}, 32'd3);
                pd_pend = 1 + int'($urandom_range(0, max_lat));
                pd_new = 1;
            end
            if (status[6:4] == 3'd5) begin
                done_seen = 1;
            end else begin
                if (sd_pend > 0 && !sd_new) begin
                    sd_pend--;
                    if (sd_pend == 0) begin
                        solver_done = 1'b1;
                        after_sd = 1;
                    end else if ($urandom_range(0, 3) == 0) begin
                        print_done = 1'b1;  // stray pulse, must be ignored
                    end
                end
                if (pd_pend > 0 && !pd_new) begin
                    pd_pend--;
                    if (pd_pend == 0) begin
                        print_done = 1'b1;
                        after_pd = 1;
                    end else if ($urandom_range(0, 3) == 0) begin
                        solver_done = 1'b1;  // stray pulse, must be ignored
                    end
                end
            end
        end
        if (!done_seen) begin
            bound_expired($sformatf("%s_reach_done", tag));
        end else begin
            check($sformatf("%s_event_count", tag), got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i < got_q.size())
                    check($sformatf("%s_event_%0d", tag, i), got_q[i], exp_q[i]);
            end
            check($sformatf("%s_iter_count", tag), {16'd0, iter_count}, n);
            check($sformatf("%s_done_status", tag), {24'd0, status}, 32'h52);
            check($sformatf("%s_done_busy", tag), {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int ns, np, pulses;

        vecs[0] = '{n: 3, ivl: 0, exp_starts: 3, exp_prints: 1};
        vecs[1] = '{n: 6, ivl: 2, exp_starts: 6, exp_prints: 3};
        vecs[2] = '{n: 0, ivl: 0, exp_starts: 0, exp_prints: 1};
        vecs[3] = '{n: 5, ivl: 3, exp_starts: 5, exp_prints: 2};
        vecs[4] = '{n: 4, ivl: 1, exp_starts: 4, exp_prints: 4};
        vecs[5] = '{n: 1, ivl: 5, exp_starts: 1, exp_prints: 1};
        vecs[6] = '{n: 7, ivl: 7, exp_starts: 7, exp_prints: 1};

        reset = 1'b1; cmd = 8'h00; num_iter = 16'd0; solver_done = 1'b0; print_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_status", {24'd0, status}, 32'h00);
        check("reset_iter_count", {16'd0, iter_count}, 32'd0);
        check("reset_pulses_busy", {29'd0, solver_start, print_start, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_status", {24'd0, status}, 32'h00);

        // Table-driven runs
        for (int v = 0; v < 7; v++) begin
            run_check(vecs[v].n, vecs[v].ivl, v % 3, $sformatf("vec%0d", v), ns, np);
            check($sformatf("vec%0d_solver_starts", v), ns, vecs[v].exp_starts);
            check($sformatf("vec%0d_print_starts", v), np, vecs[v].exp_prints);
        end

        // Randomized runs against the model
        for (int r = 0; r < 6; r++) begin
            run_check(int'($urandom_range(0, 20)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 5)), $sformatf("rand%0d", r), ns, np);
        end

        // Held start after DONE must not retrigger; a fresh edge must
        run_check(2, 0, 1, "hold", ns, np);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (solver_start || print_start) pulses++;
        end
        check("hold_no_retrigger", pulses, 0);
        check("hold_still_done", {24'd0, status}, 32'h52);
        cmd = 8'h00;
        @(negedge clk);
        check("hold_release_idle", {24'd0, status}, 32'h02);
        cmd = 8'h01;
        @(negedge clk);
        check("hold_restart_status", {24'd0, status}, 32'h11);
        check("hold_restart_pulse", {31'd0, solver_start}, 32'd1);
        cmd = 8'h03;
        @(negedge clk);
        check("abort_in_wait_status", {24'd0, status}, 32'h04);
        cmd = 8'h00;

        // Abort coincident with solver_done of iteration 2
        @(negedge clk);
        num_iter = 16'd5;
        @(negedge clk);
        cmd = 8'h01;
        @(negedge clk);
        check("abort_seq_step1", {31'd0, solver_start}, 32'd1);
        @(negedge clk);
        solver_done = 1'b1;
        @(negedge clk);
        solver_done = 1'b0;
        check("abort_seq_step2", {31'd0, solver_start}, 32'd1);
        check("abort_seq_iter1", {16'd0, iter_count}, 32'd1);
        @(negedge clk);
        solver_done = 1'b1;
        cmd = 8'h03;
        @(negedge clk);
        solver_done = 1'b0;
        cmd = 8'h01;
        check("abort_status", {24'd0, status}, 32'h04);
        check("abort_iter_count", {16'd0, iter_count}, 32'd1);
        pulses = 0;
        repeat (6) begin
            if (solver_start || print_start) pulses++;
            @(negedge clk);
        end
        check("abort_no_pulses", pulses, 0);
        cmd = 8'h00;
        @(negedge clk);
        cmd = 8'h01;
        @(negedge clk);
        check("abort_restart_status", {24'd0, status}, 32'h11);

        // Reset in the middle of a run
        @(negedge clk);
        solver_done = 1'b1;
        @(negedge clk);
        solver_done = 1'b0;
        @(negedge clk);
        check("midrun_iter_before_reset", {16'd0, iter_count}, 32'd1);
        reset = 1'b1;
        cmd = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        check("midrun_reset_status", {24'd0, status}, 32'h00);
        check("midrun_reset_iter", {16'd0, iter_count}, 32'd0);
        check("midrun_reset_pulses", {29'd0, solver_start, print_start, busy}, 32'd0);

`ifdef LBM_SEQ_WATCHDOG_EN
        // Withheld solver_done: 16 cycles in WAIT_STEP, then DONE with timeout
        num_iter = 16'd3;
        @(negedge clk);
        cmd = 8'h01;
        @(negedge clk);
        check("wd_step_pulse", {31'd0, solver_start}, 32'd1);
        repeat (16) @(negedge clk);
        check("wd_still_waiting", {29'd0, status[6:4]}, 32'd2);
        @(negedge clk);
        check("wd_timeout_status", {24'd0, status}, 32'h5A);
        cmd = 8'h00;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
